// File: rtl/i2c_regfile_ctrl_if.sv
// Byte-level bus between the I2C slave core and the register-file controller.
// The I2C slave core sits on the master modport and the controller on the slave modport.
interface i2c_regfile_ctrl_if;
    logic [7:0] slv_rx_data;
    logic       slv_rx_valid;
    logic       slv_wr_down;
    logic       slv_wr_up;
    logic       slv_write_ok;
    logic [7:0] slv_tx_data;
    logic       slv_data_incoming;

    // The I2C slave core drives the receive and status signals and takes the transmit byte.
    modport master (
        output slv_rx_data,
        output slv_rx_valid,
        output slv_wr_down,
        output slv_wr_up,
        output slv_write_ok,
        input  slv_tx_data,
        input  slv_data_incoming
    );

    // The register-file controller consumes received bytes and feeds the PISO.
    modport slave (
        input  slv_rx_data,
        input  slv_rx_valid,
        input  slv_wr_down,
        input  slv_wr_up,
        input  slv_write_ok,
        output slv_tx_data,
        output slv_data_incoming
    );
endinterface

// File: rtl/i2c_regfile_ctrl.sv
// Register-file controller behind an I2C slave byte interface.
// A shared pointer is loaded by the first byte of a master write, auto-increments
// on each data byte and on each transmit load. A local write port shares the
// register file, and I2C writes win same-address collisions.
module i2c_regfile_ctrl #(
    parameter int NREGS = 8,
    parameter int PW    = $clog2(NREGS)
) (
    input  logic                 clock,
    input  logic                 reset,
    i2c_regfile_ctrl_if.slave    slv,
    input  logic                 lcl_we,
    input  logic [PW-1:0]        lcl_addr,
    input  logic [7:0]           lcl_wdata,
    output logic                 lcl_collide,
    output logic                 tx_underrun,
    output logic [PW-1:0]        ptr,
    output logic [8*NREGS-1:0]   regs_flat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PTR,
        ST_DATA
    } rx_state_t;

    rx_state_t  state_q;
    rx_state_t  state_d;

    logic       wr_down_q;
    logic       wr_up_r;
    logic       wr_up_q;

    logic [7:0] regs [NREGS];

    logic       ptr_load;
    logic       i2c_we;
    logic       rx_accept;
    logic       tx_rise;
    logic       tx_load;
    logic       tx_block;
    logic       lcl_hit;
    logic       lcl_ok;

    // Receive FSM next state: the first byte after the address ACK is the pointer, the rest are data.
    always_comb begin
        state_d  = state_q;
        ptr_load = 1'b0;
        i2c_we   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (slv.slv_wr_down && !wr_down_q) begin
                    state_d = ST_PTR;
                end
            end
            ST_PTR: begin
                if (slv.slv_rx_valid) begin
                    ptr_load = 1'b1;
                    state_d  = ST_DATA;
                end
                if (!slv.slv_wr_down) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (slv.slv_rx_valid) begin
                    i2c_we = 1'b1;
                end
                if (!slv.slv_wr_down) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Arbitration between receive, transmit and the local port for this cycle.
    always_comb begin
        rx_accept = ptr_load | i2c_we;
        tx_rise   = wr_up_r & ~wr_up_q;
        tx_load   = tx_rise & slv.slv_write_ok & ~rx_accept;
        tx_block  = tx_rise & ~tx_load;
        lcl_hit   = lcl_we & i2c_we & (lcl_addr == ptr);
        lcl_ok    = lcl_we & ~lcl_hit;
    end

    // Receive FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // wr_down tracks the pin even through reset, so a transaction already open at reset release is not mistaken for a new one.
    always_ff @(posedge clock) begin
        wr_down_q <= slv.slv_wr_down;
    end

    // Two-stage wr_up history; clearing both on reset makes a level already high at release count as a rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_up_r <= 1'b0;
            wr_up_q <= 1'b0;
        end else begin
            wr_up_r <= slv.slv_wr_up;
            wr_up_q <= wr_up_r;
        end
    end

    // Shared pointer: receive activity takes precedence over a transmit load in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr_load) begin
            ptr <= slv.slv_rx_data[PW-1:0];
        end else if (i2c_we || tx_load) begin
            ptr <= ptr + PW'(1);
        end
    end

    // Register file: I2C data writes and local writes land together unless they target the same register.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (i2c_we && (ptr == PW'(i))) begin
                    regs[i] <= slv.slv_rx_data;
                end else if (lcl_ok && (lcl_addr == PW'(i))) begin
                    regs[i] <= lcl_wdata;
                end
            end
        end
    end

    // Registered outputs; the transmit byte holds between loads so the slave can sample it at leisure.
    always_ff @(posedge clock) begin
        if (reset) begin
            slv.slv_tx_data       <= 8'h00;
            slv.slv_data_incoming <= 1'b0;
            lcl_collide           <= 1'b0;
            tx_underrun           <= 1'b0;
        end else begin
            if (tx_load) begin
                slv.slv_tx_data <= regs[ptr];
            end
            slv.slv_data_incoming <= tx_load;
            lcl_collide           <= lcl_hit;
            tx_underrun           <= tx_block;
        end
    end

    // Flatten the register array for chip configuration.
    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[8*i +: 8] = regs[i];
        end
    end

endmodule

// File: tb/tb_i2c_regfile_ctrl.sv
// Self-checking bench for i2c_regfile_ctrl (NREGS=8).
// Transmit loads are checked through a scoreboard queue; everything else inline per test.
module tb_i2c_regfile_ctrl;

    logic        clock;
    logic        reset;
    logic        lcl_we;
    logic [2:0]  lcl_addr;
    logic [7:0]  lcl_wdata;
    logic        lcl_collide;
    logic        tx_underrun;
    logic [2:0]  ptr;
    logic [63:0] regs_flat;

    i2c_regfile_ctrl_if bus ();

    i2c_regfile_ctrl #(.NREGS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .slv         (bus),
        .lcl_we      (lcl_we),
        .lcl_addr    (lcl_addr),
        .lcl_wdata   (lcl_wdata),
        .lcl_collide (lcl_collide),
        .tx_underrun (tx_underrun),
        .ptr         (ptr),
        .regs_flat   (regs_flat)
    );

    int         check_count = 0;
    int         pass_count  = 0;
    logic [7:0] exp_q [$];

    // Free-running clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, passed=%0d total=%0d", pass_count, check_count);
        $fatal(1, "[TB] watchdog expired");
    end

    // Scoreboard: every PISO load must match the oldest expected byte.
    always @(negedge clock) begin
        if (bus.slv_data_incoming === 1'b1) begin
            check_count++;
            if (exp_q.size() == 0) begin
                $display("[TB] FAIL tx_load: unexpected load, slv_tx_data=%02h, nothing expected", bus.slv_tx_data);
            end else begin
                logic [7:0] exp_byte;
                exp_byte = exp_q.pop_front();
                if (bus.slv_tx_data !== exp_byte) begin
                    $display("[TB] FAIL tx_load: slv_tx_data=%02h expected=%02h", bus.slv_tx_data, exp_byte);
                end else begin
                    pass_count++;
                end
            end
        end
    end

    function automatic logic [7:0] reg_at(input int idx);
        return regs_flat[8*idx +: 8];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        bus.slv_rx_valid = 1'b1;
        bus.slv_rx_data  = b;
        tick();
        bus.slv_rx_valid = 1'b0;
    endtask

    task automatic start_write();
        bus.slv_wr_down = 1'b1;
        tick();
    endtask

    task automatic end_write();
        bus.slv_wr_down = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        reset            = 1'b1;
        lcl_we           = 1'b0;
        lcl_addr         = 3'd0;
        lcl_wdata        = 8'h00;
        bus.slv_rx_data  = 8'h00;
        bus.slv_rx_valid = 1'b0;
        bus.slv_wr_down  = 1'b0;
        bus.slv_wr_up    = 1'b0;
        bus.slv_write_ok = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_count++;
        if ({bus.slv_tx_data, bus.slv_data_incoming, lcl_collide, tx_underrun} !== 11'd0)
            $display("[TB] FAIL reset_outputs: tx=%02h inc=%b col=%b und=%b expected all 0",
                     bus.slv_tx_data, bus.slv_data_incoming, lcl_collide, tx_underrun);
        else pass_count++;
        check_count++;
        if (ptr !== 3'd0 || regs_flat !== 64'd0)
            $display("[TB] FAIL reset_state: ptr=%0d regs=%016h expected 0/0", ptr, regs_flat);
        else pass_count++;
    endtask

    task automatic test_pointer_write();
        start_write();
        rx_byte(8'h03);
        rx_byte(8'hA5);
        rx_byte(8'h5A);
        end_write();
        check_count++;
        if (reg_at(3) !== 8'hA5 || reg_at(4) !== 8'h5A)
            $display("[TB] FAIL ptr_write_regs: r3=%02h r4=%02h expected A5/5A", reg_at(3), reg_at(4));
        else pass_count++;
        check_count++;
        if (ptr !== 3'd5)
            $display("[TB] FAIL ptr_write_ptr: ptr=%0d expected 5", ptr);
        else pass_count++;
        // A byte arriving with no transaction open must be ignored.
        rx_byte(8'hEE);
        tick();
        check_count++;
        if (reg_at(5) !== 8'h00 || ptr !== 3'd5)
            $display("[TB] FAIL idle_ignore: r5=%02h ptr=%0d expected 00/5", reg_at(5), ptr);
        else pass_count++;
    endtask

    task automatic test_wrap();
        start_write();
        rx_byte(8'h07);
        rx_byte(8'h11);
        rx_byte(8'h22);
        end_write();
        check_count++;
        if (reg_at(7) !== 8'h11 || reg_at(0) !== 8'h22 || ptr !== 3'd1)
            $display("[TB] FAIL wrap: r7=%02h r0=%02h ptr=%0d expected 11/22/1", reg_at(7), reg_at(0), ptr);
        else pass_count++;
        start_write();
        rx_byte(8'hFA);
        end_write();
        check_count++;
        if (ptr !== 3'd2)
            $display("[TB] FAIL ptr_modulo: ptr=%0d expected 2", ptr);
        else pass_count++;
    endtask

    task automatic test_transmit();
        lcl_we    = 1'b1;
        lcl_addr  = 3'd2;
        lcl_wdata = 8'h9C;
        tick();
        lcl_addr  = 3'd3;
        lcl_wdata = 8'h3E;
        tick();
        lcl_we    = 1'b0;
        start_write();
        rx_byte(8'h02);
        end_write();
        check_count++;
        if (reg_at(2) !== 8'h9C || reg_at(3) !== 8'h3E || ptr !== 3'd2)
            $display("[TB] FAIL local_preload: r2=%02h r3=%02h ptr=%0d expected 9C/3E/2", reg_at(2), reg_at(3), ptr);
        else pass_count++;
        bus.slv_write_ok = 1'b1;
        exp_q.push_back(8'h9C);
        bus.slv_wr_up = 1'b1;
        tick();
        bus.slv_wr_up = 1'b0;
        check_count++;
        if (bus.slv_data_incoming !== 1'b0)
            $display("[TB] FAIL tx_latency_early: slv_data_incoming=%b expected 0 one cycle after rise", bus.slv_data_incoming);
        else pass_count++;
        tick();
        check_count++;
        if (bus.slv_data_incoming !== 1'b1)
            $display("[TB] FAIL tx_latency: slv_data_incoming=%b expected 1 two cycles after rise", bus.slv_data_incoming);
        else pass_count++;
        exp_q.push_back(8'h3E);
        bus.slv_wr_up = 1'b1;
        tick();
        bus.slv_wr_up = 1'b0;
        tick();
        tick();
        tick();
        check_count++;
        if (ptr !== 3'd4 || bus.slv_tx_data !== 8'h3E || bus.slv_data_incoming !== 1'b0)
            $display("[TB] FAIL tx_after: ptr=%0d tx=%02h inc=%b expected 4/3E/0", ptr, bus.slv_tx_data, bus.slv_data_incoming);
        else pass_count++;
    endtask

    task automatic test_underrun();
        bus.slv_write_ok = 1'b0;
        bus.slv_wr_up    = 1'b1;
        tick();
        bus.slv_wr_up    = 1'b0;
        tick();
        check_count++;
        if (tx_underrun !== 1'b1 || bus.slv_data_incoming !== 1'b0)
            $display("[TB] FAIL underrun_pulse: und=%b inc=%b expected 1/0", tx_underrun, bus.slv_data_incoming);
        else pass_count++;
        tick();
        check_count++;
        if (tx_underrun !== 1'b0 || ptr !== 3'd4)
            $display("[TB] FAIL underrun_after: und=%b ptr=%0d expected 0/4", tx_underrun, ptr);
        else pass_count++;
    endtask

    task automatic test_collision();
        start_write();
        rx_byte(8'h05);
        bus.slv_rx_valid = 1'b1;
        bus.slv_rx_data  = 8'h33;
        lcl_we           = 1'b1;
        lcl_addr         = 3'd5;
        lcl_wdata        = 8'h44;
        tick();
        bus.slv_rx_valid = 1'b0;
        lcl_we           = 1'b0;
        check_count++;
        if (reg_at(5) !== 8'h33 || lcl_collide !== 1'b1 || ptr !== 3'd6)
            $display("[TB] FAIL collide_same: r5=%02h col=%b ptr=%0d expected 33/1/6", reg_at(5), lcl_collide, ptr);
        else pass_count++;
        bus.slv_rx_valid = 1'b1;
        bus.slv_rx_data  = 8'h55;
        lcl_we           = 1'b1;
        lcl_addr         = 3'd1;
        lcl_wdata        = 8'h66;
        tick();
        bus.slv_rx_valid = 1'b0;
        lcl_we           = 1'b0;
        check_count++;
        if (reg_at(6) !== 8'h55 || reg_at(1) !== 8'h66 || lcl_collide !== 1'b0)
            $display("[TB] FAIL collide_diff: r6=%02h r1=%02h col=%b expected 55/66/0", reg_at(6), reg_at(1), lcl_collide);
        else pass_count++;
        end_write();
    endtask

    task automatic test_rx_tx_conflict();
        start_write();
        rx_byte(8'h00);
        bus.slv_write_ok = 1'b1;
        bus.slv_wr_up    = 1'b1;
        tick();
        bus.slv_wr_up    = 1'b0;
        bus.slv_rx_valid = 1'b1;
        bus.slv_rx_data  = 8'h77;
        tick();
        bus.slv_rx_valid = 1'b0;
        check_count++;
        if (tx_underrun !== 1'b1 || bus.slv_data_incoming !== 1'b0 || reg_at(0) !== 8'h77 || ptr !== 3'd1)
            $display("[TB] FAIL rx_tx_conflict: und=%b inc=%b r0=%02h ptr=%0d expected 1/0/77/1",
                     tx_underrun, bus.slv_data_incoming, reg_at(0), ptr);
        else pass_count++;
        end_write();
    endtask

    task automatic test_reset_mid();
        start_write();
        rx_byte(8'h01);
        rx_byte(8'hAB);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_count++;
        if (ptr !== 3'd0 || regs_flat !== 64'd0 || bus.slv_tx_data !== 8'h00)
            $display("[TB] FAIL reset_mid: ptr=%0d regs=%016h tx=%02h expected 0/0/00", ptr, regs_flat, bus.slv_tx_data);
        else pass_count++;
        rx_byte(8'h02);
        rx_byte(8'h99);
        tick();
        check_count++;
        if (ptr !== 3'd0 || regs_flat !== 64'd0)
            $display("[TB] FAIL reset_no_rise: ptr=%0d regs=%016h expected 0/0", ptr, regs_flat);
        else pass_count++;
        // wr_up held high across reset release counts as a fresh rise.
        bus.slv_write_ok = 1'b1;
        bus.slv_wr_up    = 1'b1;
        reset            = 1'b1;
        tick();
        reset            = 1'b0;
        exp_q.push_back(8'h00);
        tick();
        tick();
        check_count++;
        if (ptr !== 3'd1)
            $display("[TB] FAIL wr_up_at_release: ptr=%0d expected 1", ptr);
        else pass_count++;
        bus.slv_wr_up   = 1'b0;
        bus.slv_wr_down = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_pointer_write();
        test_wrap();
        test_transmit();
        test_underrun();
        test_collision();
        test_rx_tx_conflict();
        test_reset_mid();
        check_count++;
        if (exp_q.size() != 0)
            $display("[TB] FAIL scoreboard_drain: %0d loads still expected, required 0", exp_q.size());
        else pass_count++;
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/i2c_regfile_ctrl.md
# i2c_regfile_ctrl

Register-file controller that sits between the `I2C_slave` byte interface and the rest of the chip. It uses one shared register pointer, the standard I2C pointer-then-data convention.
- Master-write bytes become pointer loads and auto-incrementing register writes.
- Master-read bytes are served from the register file into the slave's PISO.
- A local write port shares the register file, and I2C writes win collisions.
- All registers are exported flat for chip configuration.

## Interface
- `NREGS`, default 8: number of 8-bit registers; a power of two, 2..16.
- `PW`, default `$clog2(NREGS)`: pointer width; derived, not overridden.

- `clock` in 1: sole clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `slv_rx_data` in 8: received byte (slave `data_out`).
- `slv_rx_valid` in 1: one-cycle strobe; `slv_rx_data` holds a new byte this cycle.
- `slv_wr_down` in 1: high while a master-write transaction is in progress after the address ACK.
- `slv_wr_up` in 1: slave transmit activity (slave `wr_up`).
- `slv_write_ok` in 1: slave PISO empty and not receiving (slave `writeOK`).
- `slv_tx_data` out 8: byte presented to slave `data_in`.
- `slv_data_incoming` out 1: PISO load request (slave `data_incoming`).
- `lcl_we` in 1: local register write strobe.
- `lcl_addr` in PW: local write address.
- `lcl_wdata` in 8: local write data.
- `lcl_collide` out 1: one-cycle pulse when a local write was dropped.
- `tx_underrun` out 1: one-cycle pulse when a transmit load could not be issued.
- `ptr` out PW: current register pointer.
- `regs_flat` out 8*NREGS: register i sits at bits [8i+7:8i].

## Operation
- Receive FSM states and transitions:
  - IDLE: on `slv_wr_down` 0->1, go to PTR.
  - PTR: on `slv_rx_valid`, set `ptr` <= `slv_rx_data[PW-1:0]` (upper bits ignored, so the pointer wraps modulo NREGS), then go to DATA.
  - DATA: on each `slv_rx_valid`, write `regs[ptr]` <= `slv_rx_data` and set `ptr` <= `ptr`+1 (wraps NREGS-1 -> 0).
  - PTR or DATA with `slv_wr_down` low: return to IDLE; `ptr` and `regs` are retained.
  - IDLE: `slv_rx_valid` is ignored.
- Transmit:
  - `slv_wr_up` is registered; a rise is `wr_up & ~wr_up_q`.
  - On a rise with `slv_write_ok`=1, the next cycle drives `slv_tx_data`=`regs[ptr]` (value before that edge) and `slv_data_incoming`=1 for exactly one cycle, and `ptr` increments.
  - On a rise with `slv_write_ok`=0: no load, `ptr` unchanged, `tx_underrun` pulses.
- Local port:
  - `lcl_we` writes `regs[lcl_addr]` <= `lcl_wdata`.
  - The local port never moves `ptr`.
- Simultaneous events:
  - I2C data write and local write to the same address: the I2C value is stored and `lcl_collide` pulses.
  - Same case with different addresses: both writes land.
  - `slv_rx_valid` in PTR/DATA in the same cycle as a `slv_wr_up` rise: the receive side is processed, the transmit load is suppressed, and `tx_underrun` pulses.
  - `slv_rx_valid` and `slv_wr_down` falling in the same cycle: the byte is processed, then the FSM enters IDLE.
- Reset mid-transaction:
  - FSM goes to IDLE, `ptr`=0, all `regs`=0.
  - `wr_up_q`=0, so a `slv_wr_up` already high at reset release counts as a rise.

## Timing
- All outputs are registered.
- Reset values: `slv_tx_data`=0, `slv_data_incoming`=0, `lcl_collide`=0, `tx_underrun`=0, `ptr`=0, `regs_flat`=0.
- Latency:
  - Register write visible on `regs_flat` 1 cycle after the strobe.
  - Pointer load or increment visible on `ptr` 1 cycle after the strobe.
  - `slv_data_incoming` asserts 2 cycles after `slv_wr_up` rises at the pin (1 register stage plus 1 output stage).
- `slv_tx_data` holds its value until the next load, so it stays stable while the slave samples it.
- Throughput: one receive byte per cycle and one transmit load per `slv_wr_up` rise, with no internal backpressure.

## Test plan
- Reset, then `slv_wr_down`=1, rx bytes 0x03, 0xA5, 0x5A, then `slv_wr_down`=0 -> `regs[3]`=0xA5, `regs[4]`=0x5A, `ptr`=5, FSM back in IDLE.
- Write pointer 0x07, then bytes 0x11, 0x22 (NREGS=8) -> `regs[7]`=0x11, `regs[0]`=0x22 (wrap), `ptr`=1; separately, pointer byte 0xFA -> `ptr`=2.
- Preload `regs[2]`=0x9C, set `ptr`=2, `slv_write_ok`=1, pulse `slv_wr_up` twice -> two one-cycle `slv_data_incoming` pulses with `slv_tx_data`=0x9C then `regs[3]`, final `ptr`=4.
- `slv_wr_up` rise with `slv_write_ok`=0 -> no `slv_data_incoming`, `tx_underrun`=1 for one cycle, `ptr` unchanged.
- Same-cycle I2C data write 0x33 and `lcl_we` 0x44 to the same address -> register=0x33 and `lcl_collide` pulses; repeat with different addresses -> both registers updated, no pulse.
- Assert `reset` mid-DATA after one byte -> next cycle `ptr`=0, `regs_flat`=0, IDLE; a following rx byte with `slv_wr_down` still high but no new rise is ignored.
